// File: rtl/coffee_sequencer.sv
// Coffee vending controller: collects credit, checks price through an external
// registered comparator, brews, then returns change one unit per cycle.
module coffee_sequencer #(
    parameter int BREW_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [3:0] coin_val,
    input  logic       sel_valid,
    input  logic [2:0] sel,
    input  logic       cancel,
    input  logic       cmp_ok,
    input  logic [3:0] cmp_cambio,
    output logic [3:0] dinero,
    output logic [2:0] c_type,
    output logic       coin_reject,
    output logic       brew_on,
    output logic       change_pulse,
    output logic       done,
    output logic       busy,
    output logic [3:0] credit
);

    localparam int BW = $clog2(BREW_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_BREW,
        S_CHANGE
    } state_t;

    state_t          r_state,    w_state_nxt;
    logic [3:0]      r_credit,   w_credit_nxt;
    logic [3:0]      r_dinero,   w_dinero_nxt;
    logic [2:0]      r_ctype,    w_ctype_nxt;
    logic [3:0]      r_pending,  w_pending_nxt;
    logic [BW-1:0]   r_brew_cnt, w_brew_cnt_nxt;
    logic [TW-1:0]   r_to_cnt,   w_to_cnt_nxt;
    logic            r_chk,      w_chk_nxt;
    logic            r_reject,   w_reject_nxt;

    logic [4:0]      w_sum;
    logic            w_sel_ok;

    assign w_sum    = {1'b0, r_credit} + {1'b0, coin_val};
    assign w_sel_ok = sel_valid && (sel >= 3'd1) && (sel <= 3'd4);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_credit   <= '0;
            r_dinero   <= '0;
            r_ctype    <= '0;
            r_pending  <= '0;
            r_brew_cnt <= '0;
            r_to_cnt   <= '0;
            r_chk      <= 1'b0;
            r_reject   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_credit   <= w_credit_nxt;
            r_dinero   <= w_dinero_nxt;
            r_ctype    <= w_ctype_nxt;
            r_pending  <= w_pending_nxt;
            r_brew_cnt <= w_brew_cnt_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_chk      <= w_chk_nxt;
            r_reject   <= w_reject_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_credit_nxt   = r_credit;
        w_dinero_nxt   = r_dinero;
        w_ctype_nxt    = r_ctype;
        w_pending_nxt  = r_pending;
        w_brew_cnt_nxt = r_brew_cnt;
        w_to_cnt_nxt   = r_to_cnt;
        w_chk_nxt      = r_chk;
        w_reject_nxt   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (coin_valid && (coin_val != 4'd0)) begin
                    w_credit_nxt = coin_val;
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (cancel) begin
                    w_pending_nxt = r_credit;
                    w_state_nxt   = S_CHANGE;
                end else if (w_sel_ok) begin
                    w_ctype_nxt  = sel;
                    w_dinero_nxt = r_credit;
                    w_chk_nxt    = 1'b0;
                    w_state_nxt  = S_CHECK;
                end else if (coin_valid && !w_sum[4]) begin
                    w_credit_nxt = w_sum[3:0];
                    w_to_cnt_nxt = '0;
                end else begin
                    // An overflowing coin is refused and does not count as activity
                    w_reject_nxt = coin_valid;
                    if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        w_pending_nxt = r_credit;
                        w_state_nxt   = S_CHANGE;
                    end else begin
                        w_to_cnt_nxt = r_to_cnt + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                w_reject_nxt = coin_valid;
                if (!r_chk) begin
                    w_chk_nxt = 1'b1;
                end else if (cmp_ok) begin
                    w_pending_nxt  = cmp_cambio;
                    w_credit_nxt   = '0;
                    w_brew_cnt_nxt = '0;
                    w_state_nxt    = S_BREW;
                end else begin
                    w_pending_nxt = r_credit;
                    w_state_nxt   = S_CHANGE;
                end
            end
            S_BREW: begin
                w_reject_nxt = coin_valid;
                if (r_brew_cnt == BW'(BREW_CYCLES - 1)) begin
                    w_state_nxt = S_CHANGE;
                end else begin
                    w_brew_cnt_nxt = r_brew_cnt + 1'b1;
                end
            end
            S_CHANGE: begin
                w_reject_nxt = coin_valid;
                if (r_pending != 4'd0) begin
                    w_pending_nxt = r_pending - 4'd1;
                end else begin
                    w_credit_nxt = '0;
                    w_dinero_nxt = '0;
                    w_ctype_nxt  = '0;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dinero       = r_dinero;
    assign c_type       = r_ctype;
    assign credit       = r_credit;
    assign coin_reject  = r_reject;
    assign brew_on      = (r_state == S_BREW);
    assign change_pulse = (r_state == S_CHANGE) && (r_pending != 4'd0);
    assign done         = (r_state == S_CHANGE) && (r_pending == 4'd0);
    assign busy         = (r_state != S_IDLE) && (r_state != S_COLLECT);

endmodule

// File: tb/tb_coffee_sequencer.sv
// Self-checking bench for coffee_sequencer with a price-table comparator
// model and transaction-level expectations.
module tb_coffee_sequencer;

    localparam int BREW = 16;
    localparam int TMO  = 255;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [3:0] coin_val;
    logic       sel_valid;
    logic [2:0] sel;
    logic       cancel;
    logic       cmp_ok;
    logic [3:0] cmp_cambio;
    logic [3:0] dinero;
    logic [2:0] c_type;
    logic       coin_reject;
    logic       brew_on;
    logic       change_pulse;
    logic       done;
    logic       busy;
    logic [3:0] credit;

    int nvec = 0;
    int nerr = 0;

    coffee_sequencer #(
        .BREW_CYCLES   (BREW),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .sel_valid   (sel_valid),
        .sel         (sel),
        .cancel      (cancel),
        .cmp_ok      (cmp_ok),
        .cmp_cambio  (cmp_cambio),
        .dinero      (dinero),
        .c_type      (c_type),
        .coin_reject (coin_reject),
        .brew_on     (brew_on),
        .change_pulse(change_pulse),
        .done        (done),
        .busy        (busy),
        .credit      (credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int price(input logic [2:0] t);
        case (t)
            3'd1:    return 3;
            3'd2:    return 4;
            3'd3:    return 5;
            3'd4:    return 7;
            default: return 16;
        endcase
    endfunction

    // Registered price comparator seen by the sequencer
    always @(posedge clk) begin
        cmp_ok     <= (int'(dinero) >= price(c_type));
        cmp_cambio <= 4'(int'(dinero) - price(c_type));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_val   = v;
        tick();
        coin_valid = 1'b0;
        coin_val   = '0;
    endtask

    task automatic pick(input logic [2:0] s);
        sel_valid = 1'b1;
        sel       = s;
        tick();
        sel_valid = 1'b0;
        sel       = '0;
    endtask

    // Observes one transaction; index 1 is the cycle after the triggering input
    task automatic run(input int start, input int budget,
                       output int brew_n, output int chg_n,
                       output int first_brew, output int first_chg,
                       output int done_idx, output bit contig);
        int last;
        brew_n = 0; chg_n = 0; first_brew = -1; first_chg = -1;
        done_idx = -1; contig = 1'b1; last = -10;
        for (int idx = start; idx < start + budget; idx++) begin
            @(negedge clk);
            if (brew_on) begin
                if (first_brew < 0) first_brew = idx;
                brew_n++;
            end
            if (change_pulse) begin
                if (chg_n > 0 && idx != last + 1) contig = 1'b0;
                if (first_chg < 0) first_chg = idx;
                last = idx;
                chg_n++;
            end
            if (done) begin
                done_idx = idx;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; coin_valid = 0; coin_val = 0;
        sel_valid = 0; sel = 0; cancel = 0;
        repeat (3) tick();
        @(negedge clk);
        nvec++;
        if ({credit, dinero, c_type} !== 11'd0) begin
            nerr++;
            $display("FAIL reset_regs got %h exp 0", {credit, dinero, c_type});
        end
        nvec++;
        if ({brew_on, change_pulse, done, busy, coin_reject} !== 5'd0) begin
            nerr++;
            $display("FAIL reset_outs got %b exp 00000",
                     {brew_on, change_pulse, done, busy, coin_reject});
        end
        rst = 1'b0;
        tick();
        pick(3'd2);
        cancel = 1'b1; tick(); cancel = 1'b0;
        @(negedge clk);
        nvec++;
        if ({busy, c_type, credit} !== 8'd0) begin
            nerr++;
            $display("FAIL idle_ignore got %h exp 0", {busy, c_type, credit});
        end
    endtask

    task automatic test_exact_price();
        int b, c, fb, fc, d;
        bit ct;
        put_coin(4'd2);
        put_coin(4'd3);
        @(negedge clk);
        nvec++;
        if (credit !== 4'd5) begin
            nerr++; $display("FAIL exact_credit got %0d exp 5", credit);
        end
        tick();
        pick(3'd3);
        @(negedge clk);
        nvec++;
        if ({dinero, c_type} !== {4'd5, 3'd3}) begin
            nerr++;
            $display("FAIL exact_latch got %0d/%0d exp 5/3", dinero, c_type);
        end
        run(2, 100, b, c, fb, fc, d, ct);
        nvec++;
        if (fb !== 3 || b !== BREW) begin
            nerr++;
            $display("FAIL exact_brew got start %0d len %0d exp 3 %0d", fb, b, BREW);
        end
        nvec++;
        if (c !== 0 || d !== 3 + BREW) begin
            nerr++;
            $display("FAIL exact_done got chg %0d done@%0d exp 0 %0d", c, d, 3 + BREW);
        end
        @(negedge clk);
        nvec++;
        if ({busy, credit, dinero, c_type} !== 12'd0) begin
            nerr++;
            $display("FAIL exact_idle got %h exp 0", {busy, credit, dinero, c_type});
        end
    endtask

    task automatic test_change();
        int b, c, fb, fc, d;
        bit ct;
        tick();
        put_coin(4'd10);
        pick(3'd1);
        run(1, 100, b, c, fb, fc, d, ct);
        nvec++;
        if (b !== BREW || fb !== 3) begin
            nerr++; $display("FAIL change_brew got %0d@%0d exp %0d@3", b, fb, BREW);
        end
        nvec++;
        if (c !== 7 || !ct || fc !== 3 + BREW) begin
            nerr++;
            $display("FAIL change_pulses got %0d contig %0d first %0d exp 7 1 %0d",
                     c, ct, fc, 3 + BREW);
        end
        nvec++;
        if (d !== 3 + BREW + 7) begin
            nerr++; $display("FAIL change_done got %0d exp %0d", d, 3 + BREW + 7);
        end
    endtask

    task automatic test_insufficient();
        int b, c, fb, fc, d;
        bit ct;
        tick();
        put_coin(4'd4);
        pick(3'd4);
        run(1, 100, b, c, fb, fc, d, ct);
        nvec++;
        if (b !== 0 || c !== 4 || fc !== 3 || d !== 7) begin
            nerr++;
            $display("FAIL insuff got brew %0d chg %0d@%0d done %0d exp 0 4@3 7",
                     b, c, fc, d);
        end
    endtask

    task automatic test_reject_cancel();
        int b, c, fb, fc, d;
        bit ct;
        tick();
        put_coin(4'd5);
        put_coin(4'd7);
        put_coin(4'd5);
        @(negedge clk);
        nvec++;
        if (coin_reject !== 1'b1 || credit !== 4'd12) begin
            nerr++;
            $display("FAIL reject got rej %b credit %0d exp 1 12", coin_reject, credit);
        end
        tick();
        cancel = 1'b1; sel_valid = 1'b1; sel = 3'd1;
        coin_valid = 1'b1; coin_val = 4'd1;
        tick();
        cancel = 1'b0; sel_valid = 1'b0; sel = 0;
        coin_valid = 1'b0; coin_val = 0;
        run(1, 100, b, c, fb, fc, d, ct);
        nvec++;
        if (b !== 0 || c !== 12 || !ct || d !== 13) begin
            nerr++;
            $display("FAIL cancel_wins got brew %0d chg %0d done %0d exp 0 12 13",
                     b, c, d);
        end
    endtask

    task automatic test_busy_coin();
        int b, c, fb, fc, d;
        bit ct;
        tick();
        put_coin(4'd6);
        pick(3'd2);
        repeat (4) tick();
        put_coin(4'd3);
        @(negedge clk);
        nvec++;
        if (coin_reject !== 1'b1 || credit !== 4'd0) begin
            nerr++;
            $display("FAIL busy_coin got rej %b credit %0d exp 1 0", coin_reject, credit);
        end
        run(7, 100, b, c, fb, fc, d, ct);
        nvec++;
        if (c !== 2 || d < 0) begin
            nerr++; $display("FAIL busy_change got %0d done %0d exp 2", c, d);
        end
    endtask

    task automatic test_timeout();
        int b, c, fb, fc, d;
        bit ct;
        tick();
        put_coin(4'd1);
        run(1, TMO + 50, b, c, fb, fc, d, ct);
        nvec++;
        if (c !== 1 || fc !== TMO + 1 || d !== TMO + 2) begin
            nerr++;
            $display("FAIL timeout got chg %0d@%0d done %0d exp 1@%0d %0d",
                     c, fc, d, TMO + 1, TMO + 2);
        end
    endtask

    task automatic test_reset_midbrew();
        int seen;
        tick();
        put_coin(4'd5);
        pick(3'd3);
        repeat (2) tick();
        repeat (4) tick();
        @(negedge clk);
        nvec++;
        if (brew_on !== 1'b1) begin
            nerr++; $display("FAIL midbrew_pre got %b exp 1", brew_on);
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        nvec++;
        if ({brew_on, credit, busy, change_pulse, done} !== 8'd0) begin
            nerr++;
            $display("FAIL midbrew_rst got %h exp 0",
                     {brew_on, credit, busy, change_pulse, done});
        end
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (change_pulse || done || brew_on) seen++;
        end
        nvec++;
        if (seen !== 0) begin
            nerr++; $display("FAIL midbrew_quiet got %0d exp 0", seen);
        end
    endtask

    task automatic test_random();
        int b, c, fb, fc, d, n, cr, v, t, ok;
        bit ct, exp_rej;
        for (int k = 0; k < 25; k++) begin
            tick();
            cr = 0;
            n = $urandom_range(1, 4);
            for (int j = 0; j < n; j++) begin
                v = $urandom_range(1, 15);
                exp_rej = (cr + v > 15);
                if (!exp_rej) cr += v;
                put_coin(4'(v));
                @(negedge clk);
                nvec++;
                if (coin_reject !== exp_rej || int'(credit) !== cr) begin
                    nerr++;
                    $display("FAIL rnd_coin got rej %b credit %0d exp %b %0d",
                             coin_reject, credit, exp_rej, cr);
                end
            end
            tick();
            t = $urandom_range(1, 4);
            ok = (cr >= price(3'(t)));
            pick(3'(t));
            run(1, 100, b, c, fb, fc, d, ct);
            nvec++;
            if (b !== (ok ? BREW : 0) || fb !== (ok ? 3 : -1)) begin
                nerr++;
                $display("FAIL rnd_brew got %0d@%0d exp ok=%0d cr=%0d t=%0d",
                         b, fb, ok, cr, t);
            end
            nvec++;
            if (c !== (ok ? cr - price(3'(t)) : cr) || !ct || d < 0) begin
                nerr++;
                $display("FAIL rnd_change got %0d done %0d exp %0d",
                         c, d, ok ? cr - price(3'(t)) : cr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_change();
        test_insufficient();
        test_reject_cancel();
        test_busy_coin();
        test_timeout();
        test_reset_midbrew();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/coffee_sequencer.md
Name: coffee_sequencer

Overview:
- Top-level vending controller for the coffee maker: accumulates inserted credit, latches the coffee selection, and drives the registered price comparator (dinero/c_type in, ok/cambio out).
- On approval it runs a timed brew cycle, then pays back change one unit per cycle.
- Refunds on cancel, on insufficient credit, or on inactivity timeout.
- Sits between the front-panel/coin inputs and the comparator/actuator outputs.

Parameters:
- BREW_CYCLES, 16, clock cycles brew_on stays high per cup (≥1).
- TIMEOUT_CYCLES, 255, idle cycles in COLLECT before automatic refund (≥1).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- coin_valid  in  1  one-cycle pulse: coin inserted
- coin_val  in  4  coin value in credit units, sampled when coin_valid=1
- sel_valid  in  1  one-cycle pulse: selection made
- sel  in  3  coffee type code, 1..4 valid, sampled when sel_valid=1
- cancel  in  1  one-cycle pulse: user abort
- cmp_ok  in  1  comparator ok
- cmp_cambio  in  4  comparator change amount
- dinero  out  4  credit presented to comparator
- c_type  out  3  type presented to comparator
- coin_reject  out  1  one-cycle pulse: coin refused, credit unchanged
- brew_on  out  1  high during brewing
- change_pulse  out  1  one pulse per returned credit unit
- done  out  1  one-cycle pulse when a transaction finishes (served or refunded)
- busy  out  1  high in every state except IDLE/COLLECT
- credit  out  4  current accumulated credit

Behaviour:
- Reset (synchronous, dominates everything, aborts any state mid-operation):
  - state=IDLE.
  - credit, dinero, c_type, pending change, brew counter and timeout counter = 0.
  - All pulse outputs = 0; brew_on = 0.
  - No refund is issued for credit held at reset.
- States: IDLE, COLLECT, CHECK, BREW, CHANGE.
- IDLE:
  - coin_valid with coin_val≠0 → credit=coin_val, go to COLLECT.
  - coin_val=0 is ignored. sel_valid and cancel are ignored.
- COLLECT:
  - Coin: credit += coin_val if the 5-bit sum ≤15; otherwise coin_reject=1 next cycle and credit holds.
  - Any accepted coin resets the timeout counter.
  - sel_valid with sel in 1..4 → latch c_type=sel, dinero=credit, go to CHECK.
  - sel outside 1..4 is ignored.
  - cancel, or timeout counter reaching TIMEOUT_CYCLES → pending change=credit, go to CHANGE.
  - Same-cycle priority: cancel > sel_valid > coin_valid. A losing coin is neither accepted nor rejected.
- CHECK:
  - Comparator is registered, so hold dinero/c_type stable for 2 cycles and sample cmp_ok/cmp_cambio on the second cycle.
  - cmp_ok=1 → pending change=cmp_cambio, credit=0, go to BREW.
  - cmp_ok=0 → pending change=credit (full refund), go to CHANGE.
  - Inputs (coin, sel, cancel) are ignored in CHECK, BREW and CHANGE; coins arriving then are flagged with coin_reject.
- BREW:
  - brew_on=1 for exactly BREW_CYCLES cycles, then go to CHANGE.
  - cancel is ignored once brewing has started.
- CHANGE:
  - If pending>0: change_pulse=1 for one cycle, pending -= 1, repeat until pending=0, giving back-to-back pulses.
  - When pending=0: done=1 for one cycle, credit=0, dinero=0, c_type=0, go to IDLE.
  - Entering with pending=0 produces no change_pulse and asserts done on the first CHANGE cycle.
- Arithmetic: 4-bit unsigned throughout. Credit saturation is handled by rejection, never by wrap-around.
- Latency:
  - sel_valid to brew_on rising = 3 cycles (1 latch + 2 CHECK).
  - Total change pulses always equal the refunded or returned amount.

Test Plan:
- Insert 2 then 3 (credit=5), sel=3 (price 5) → after 3 cycles brew_on high for 16 cycles, 0 change_pulse, done pulse, back to IDLE.
- Insert 10, sel=1 (price 3) → brew completes, then exactly 7 consecutive change_pulse, then done.
- Insert 4, sel=4 (price 7) → cmp_ok=0, brew_on never high, 4 change_pulse, done.
- Credit 12, coin_val=5 → coin_reject pulse, credit stays 12; same cycle cancel+sel_valid → cancel wins, 12 change_pulse.
- Insert 1, no activity for 255 cycles → automatic refund: 1 change_pulse, done.
- rst asserted mid-BREW (cycle 5) → next cycle brew_on=0, credit=0, state IDLE, no change_pulse and no done.
